// File: rtl/switch_pkg.sv
// switch_pkg: types and default sizes shared by the VOQ dequeue path.
//   DEF_* localparams : default sizes (must match vmu / cmu builds)
//   seg_addr_t        : cmu segment slot address
//   ctrl_word_t       : cmu control word {last, next}
//   egress_t          : egress port / VOQ index
//   vde_state_e       : dequeue engine FSM state encoding
package switch_pkg;

  localparam int DEF_PACKET_CNT = 1024;
  localparam int DEF_EGRESS_CNT = 4;
  localparam int DEF_SEG_CNT    = 1024;
  localparam int DEF_DATA_WIDTH = 32;

  localparam int SEG_AW = $clog2(DEF_SEG_CNT);
  localparam int EGR_W  = $clog2(DEF_EGRESS_CNT);

  typedef logic [SEG_AW-1:0] seg_addr_t;

  typedef struct packed {
    logic      last;
    seg_addr_t next;
  } ctrl_word_t;

  typedef logic [EGR_W-1:0] egress_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    META = 3'd1,
    RD   = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } vde_state_e;

endpackage

// File: rtl/voq_dequeue_engine_seg_tx_reg.sv
// seg_tx_reg: output holding register for one segment toward the crossbar.
//   clk, rst_n              : clock, async active-low reset (drops tx_valid)
//   load                    : capture ld_* and raise tx_valid
//   ld_data/sop/eop/egress  : segment to present
//   tx_ready                : downstream accept
//   tx_valid/data/sop/eop/egress : registered segment toward the crossbar
//
// Handshake: a segment transfers on any cycle where tx_valid && tx_ready.
// While tx_valid is high and tx_ready is low, every tx_* output holds its
// value. load is only issued while the register is empty.
module seg_tx_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int EW         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_sop,
  input  logic                  ld_eop,
  input  logic [EW-1:0]         ld_egress,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [EW-1:0]         tx_egress
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      tx_sop    <= 1'b0;
      tx_eop    <= 1'b0;
      tx_egress <= '0;
    end else if (load) begin
      tx_valid  <= 1'b1;
      tx_data   <= ld_data;
      tx_sop    <= ld_sop;
      tx_eop    <= ld_eop;
      tx_egress <= ld_egress;
    end else if (tx_valid && tx_ready) begin
      tx_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/voq_dequeue_engine.sv
// voq_dequeue_engine: on a scheduler grant, dequeues one packet descriptor
// from vmu, walks its segment chain in cmu, streams segments to the crossbar
// and returns each sent segment to the cmu free list.
//   clk, rst_n                      : clock, async active-low reset
//   grant_valid, grant_egress       : scheduler grant (sampled in IDLE only)
//   grant_done, grant_sent          : 1-cycle completion pulse + sent/empty flag
//   voq_is_empty                    : per-VOQ empty flags from vmu
//   voq_dequeue_en, voq_dequeue_sel : dequeue request to vmu
//   voq_meta                        : descriptor, valid the cycle after dequeue
//   ctrl_ra/ctrl_q, data_ra/data_q  : cmu control / data reads, 1-cycle latency
//   seg_free_en, seg_free_addr      : segment return to cmu free list
//   tx_*                            : segment stream toward the crossbar
//   state_dbg                       : current FSM state
module voq_dequeue_engine
  import switch_pkg::*;
#(
  parameter int PACKET_CNT = DEF_PACKET_CNT,
  parameter int EGRESS_CNT = DEF_EGRESS_CNT,
  parameter int SEG_CNT    = DEF_SEG_CNT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int AW        = $clog2(SEG_CNT),
  localparam int EW        = $clog2(EGRESS_CNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grant_valid,
  input  logic [EW-1:0]         grant_egress,
  output logic                  grant_done,
  output logic                  grant_sent,
  input  logic [EGRESS_CNT-1:0] voq_is_empty,
  output logic                  voq_dequeue_en,
  output logic [EW-1:0]         voq_dequeue_sel,
  input  logic [31:0]           voq_meta,
  output logic [AW-1:0]         ctrl_ra,
  input  logic [AW:0]           ctrl_q,
  output logic [AW-1:0]         data_ra,
  input  logic [DATA_WIDTH-1:0] data_q,
  output logic                  seg_free_en,
  output logic [AW-1:0]         seg_free_addr,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [EW-1:0]         tx_egress,
  output vde_state_e            state_dbg
);

  vde_state_e    state;
  logic [EW-1:0] egress_q;
  logic [AW-1:0] seg_addr;
  logic [AW-1:0] next_q;
  logic          last_q;
  logic          first;
  logic          grant_take;
  logic          tx_accept;
  logic          unused_bits;

  // A grant is only taken in IDLE, and not in the cycle grant_done is still
  // visible, so a new grant is honoured no earlier than the cycle after it.
  assign grant_take = (state == IDLE) && grant_valid && !grant_done;

  // The dequeue request is issued in the grant cycle itself so that vmu's
  // descriptor lands while the FSM sits in META.
  assign voq_dequeue_en  = grant_take && !voq_is_empty[grant_egress];
  assign voq_dequeue_sel = voq_dequeue_en ? grant_egress : '0;

  // Control and data memories are read with the same address.
  assign data_ra   = ctrl_ra;
  assign tx_accept = tx_valid && tx_ready;
  assign state_dbg = state;

  // Descriptor bits above the segment address and PACKET_CNT are not needed here.
  assign unused_bits = ^{voq_meta[31:AW], 1'(PACKET_CNT != 0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      egress_q      <= '0;
      seg_addr      <= '0;
      next_q        <= '0;
      last_q        <= 1'b0;
      first         <= 1'b0;
      ctrl_ra       <= '0;
      seg_free_en   <= 1'b0;
      seg_free_addr <= '0;
      grant_done    <= 1'b0;
      grant_sent    <= 1'b0;
    end else begin
      seg_free_en <= 1'b0;
      grant_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_take) begin
            egress_q <= grant_egress;
            if (voq_is_empty[grant_egress]) begin
              grant_sent <= 1'b0;
              state      <= DONE;
            end else begin
              state      <= META;
            end
          end
        end
        META: begin
          seg_addr <= voq_meta[AW-1:0];
          ctrl_ra  <= voq_meta[AW-1:0];
          first    <= 1'b1;
          state    <= RD;
        end
        RD: begin
          // ctrl_ra is already presented; cmu answers next cycle.
          state <= WAIT;
        end
        WAIT: begin
          last_q <= ctrl_q[AW];
          next_q <= ctrl_q[AW-1:0];
          state  <= SEND;
        end
        SEND: begin
          if (tx_accept) begin
            seg_free_en   <= 1'b1;
            seg_free_addr <= seg_addr;
            first         <= 1'b0;
            if (last_q) begin
              grant_sent <= 1'b1;
              state      <= DONE;
            end else begin
              // next_addr is used verbatim; wrap is the producer's job.
              seg_addr <= next_q;
              ctrl_ra  <= next_q;
              state    <= RD;
            end
          end
        end
        DONE: begin
          grant_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Loaded during WAIT straight from the cmu read data.
  seg_tx_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .EW         (EW)
  ) u_seg_tx_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state == WAIT),
    .ld_data   (data_q),
    .ld_sop    (first),
    .ld_eop    (ctrl_q[AW]),
    .ld_egress (egress_q),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_egress (tx_egress)
  );

endmodule

// File: tb/tb_voq_dequeue_engine.sv
module tb_voq_dequeue_engine;
  import switch_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int EW  = 2;
  localparam int EC  = 4;
  localparam int SEG = 1024;
  localparam int IW  = AW + 2 + EW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          grant_valid = 1'b0;
  logic [EW-1:0] grant_egress = '0;
  logic          grant_done, grant_sent;
  logic [EC-1:0] voq_is_empty = '0;
  logic          voq_dequeue_en;
  logic [EW-1:0] voq_dequeue_sel;
  logic [31:0]   voq_meta = '0;
  logic [AW-1:0] ctrl_ra, data_ra;
  logic [AW:0]   ctrl_q = '0;
  logic [DW-1:0] data_q = '0;
  logic          seg_free_en;
  logic [AW-1:0] seg_free_addr;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [DW-1:0] tx_data;
  logic          tx_sop, tx_eop;
  logic [EW-1:0] tx_egress;
  vde_state_e    state_dbg;

  voq_dequeue_engine dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .grant_valid     (grant_valid),
    .grant_egress    (grant_egress),
    .grant_done      (grant_done),
    .grant_sent      (grant_sent),
    .voq_is_empty    (voq_is_empty),
    .voq_dequeue_en  (voq_dequeue_en),
    .voq_dequeue_sel (voq_dequeue_sel),
    .voq_meta        (voq_meta),
    .ctrl_ra         (ctrl_ra),
    .ctrl_q          (ctrl_q),
    .data_ra         (data_ra),
    .data_q          (data_q),
    .seg_free_en     (seg_free_en),
    .seg_free_addr   (seg_free_addr),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data),
    .tx_sop          (tx_sop),
    .tx_eop          (tx_eop),
    .tx_egress       (tx_egress),
    .state_dbg       (state_dbg)
  );

  // ---------------- vmu / cmu models ----------------
  logic [31:0]   meta_next = '0;
  logic [AW:0]   ctrl_mem [SEG];
  logic [DW-1:0] data_mem [SEG];

  always @(posedge clk) begin
    if (voq_dequeue_en) voq_meta <= meta_next;
    ctrl_q <= ctrl_mem[ctrl_ra];
    data_q <= data_mem[data_ra];
  end

  // ---------------- scoreboard ----------------
  logic [IW-1:0] exp_q[$];
  logic [AW-1:0] exp_free_q[$];
  logic          exp_done_q[$];
  int            acc_cyc_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int deq_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int g_cyc = 0;
  int first_rise = -1;
  logic tx_valid_d = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [IW-1:0] pack(input logic [AW-1:0] a, input logic s, input logic e,
                                         input logic [EW-1:0] g, input logic [DW-1:0] d);
    return {a, s, e, g, d};
  endfunction

  // Monitor: pops expectations whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (voq_dequeue_en) begin
        deq_cnt++;
        check("deq_while_empty", 64'(voq_is_empty[voq_dequeue_sel]), 64'd0);
      end
      if (tx_valid && !tx_valid_d && first_rise < 0) first_rise = cyc;
      if (tx_valid && tx_ready) begin
        acc_cyc_q.push_back(cyc);
        check("data_ra_eq_ctrl_ra", 64'(data_ra), 64'(ctrl_ra));
        if (exp_q.size() == 0) check("tx_unexpected", 64'd1, 64'd0);
        else check("tx_seg", 64'(pack(ctrl_ra, tx_sop, tx_eop, tx_egress, tx_data)), 64'(exp_q.pop_front()));
      end
      if (seg_free_en) begin
        if (exp_free_q.size() == 0) check("free_unexpected", 64'd1, 64'd0);
        else check("free_addr", 64'(seg_free_addr), 64'(exp_free_q.pop_front()));
      end
      if (grant_done) begin
        done_cyc = cyc;
        if (exp_done_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
        else check("grant_sent", 64'(grant_sent), 64'(exp_done_q.pop_front()));
        done_cnt++;
      end
    end
    tx_valid_d = tx_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic add_seg(input logic [AW-1:0] a, input logic last, input logic [AW-1:0] nxt,
                         input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] g);
    ctrl_mem[a] = {last, nxt};
    data_mem[a] = d;
    exp_q.push_back(pack(a, s, e, g, d));
    exp_free_q.push_back(a);
  endtask

  task automatic send_grant(input logic [EW-1:0] e);
    @(posedge clk); #1;
    grant_valid  = 1'b1;
    grant_egress = e;
    g_cyc        = cyc;
    first_rise   = -1;
    @(posedge clk); #1;
    grant_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) @(negedge clk);
    check(name, 64'(done_cnt != start), 64'd1);
  endtask

  task automatic wait_tx_valid(input int budget, input string name);
    for (int i = 0; i < budget && !tx_valid; i++) @(negedge clk);
    check(name, 64'(tx_valid), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl_outs"}, 64'({grant_done, grant_sent, voq_dequeue_en, voq_dequeue_sel,
                                    seg_free_en, tx_valid, tx_sop, tx_eop, tx_egress}), 64'd0);
    check({tag, "_addr_outs"}, 64'({ctrl_ra, data_ra, seg_free_addr}), 64'd0);
    check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int snap;
    for (int i = 0; i < SEG; i++) begin
      ctrl_mem[i] = '0;
      data_mem[i] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1) grant to an empty VOQ: no dequeue, no tx, done with sent=0 two cycles later
    voq_is_empty = 4'b0100;
    snap = deq_cnt;
    exp_done_q.push_back(1'b0);
    send_grant(2'd2);
    wait_done(20, "t1_done_seen");
    check("t1_done_latency", 64'(done_cyc - g_cyc), 64'd2);
    check("t1_no_dequeue", 64'(deq_cnt - snap), 64'd0);
    check("t1_no_tx", 64'(first_rise < 0), 64'd1);
    voq_is_empty = 4'b0000;

    // 2) single-segment packet; upper meta bits must be ignored
    meta_next = 32'hABC0_0005;
    snap = deq_cnt;
    add_seg(10'h005, 1'b1, 10'h03A, 32'hCAFE_F00D, 1'b1, 1'b1, 2'd1);
    exp_done_q.push_back(1'b1);
    send_grant(2'd1);
    wait_done(50, "t2_done_seen");
    check("t2_first_tx_latency", 64'(first_rise - g_cyc), 64'd4);
    check("t2_one_dequeue", 64'(deq_cnt - snap), 64'd1);

    // 3) 3-segment chain including top address 0x3FF
    meta_next = 32'h0000_0010;
    add_seg(10'h010, 1'b0, 10'h011, 32'h1111_1111, 1'b1, 1'b0, 2'd3);
    add_seg(10'h011, 1'b0, 10'h3FF, 32'h2222_2222, 1'b0, 1'b0, 2'd3);
    add_seg(10'h3FF, 1'b1, 10'h000, 32'h3333_3333, 1'b0, 1'b1, 2'd3);
    exp_done_q.push_back(1'b1);
    acc_cyc_q.delete();
    send_grant(2'd3);
    wait_done(100, "t3_done_seen");
    check("t3_accept_count", 64'(acc_cyc_q.size()), 64'd3);
    if (acc_cyc_q.size() == 3) begin
      check("t3_gap_seg2", 64'(acc_cyc_q[1] - acc_cyc_q[0]), 64'd3);
      check("t3_gap_seg3", 64'(acc_cyc_q[2] - acc_cyc_q[1]), 64'd3);
    end

    // 4) backpressure on segment 2 for 5 cycles
    meta_next = 32'h0000_0020;
    add_seg(10'h020, 1'b0, 10'h021, 32'hA0A0_A0A0, 1'b1, 1'b0, 2'd0);
    add_seg(10'h021, 1'b0, 10'h022, 32'hB0B0_B0B0, 1'b0, 1'b0, 2'd0);
    add_seg(10'h022, 1'b1, 10'h000, 32'hC0C0_C0C0, 1'b0, 1'b1, 2'd0);
    exp_done_q.push_back(1'b1);
    tx_ready = 1'b0;
    send_grant(2'd0);
    wait_tx_valid(50, "t4_seg1_valid");
    @(posedge clk); #1; tx_ready = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    wait_tx_valid(50, "t4_seg2_valid");
    repeat (5) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(tx_valid), 64'd1);
      check("t4_hold_data", 64'(tx_data), 64'h0000_0000_B0B0_B0B0);
      check("t4_hold_no_free", 64'(seg_free_en), 64'd0);
      check("t4_hold_ctrl_ra", 64'(ctrl_ra), 64'h021);
    end
    @(posedge clk); #1; tx_ready = 1'b1;
    wait_done(100, "t4_done_seen");

    // 5) grant pulses while stalled in SEND are ignored
    meta_next = 32'h0000_0030;
    add_seg(10'h030, 1'b0, 10'h031, 32'h3030_3030, 1'b1, 1'b0, 2'd1);
    add_seg(10'h031, 1'b1, 10'h000, 32'h3131_3131, 1'b0, 1'b1, 2'd1);
    exp_done_q.push_back(1'b1);
    snap = deq_cnt;
    tx_ready = 1'b0;
    send_grant(2'd1);
    wait_tx_valid(50, "t5_seg1_valid");
    repeat (3) begin
      @(posedge clk); #1; grant_valid = 1'b1; grant_egress = 2'd0;
      @(posedge clk); #1; grant_valid = 1'b0;
    end
    tx_ready = 1'b1;
    wait_done(100, "t5_done_seen");
    repeat (10) @(negedge clk);
    check("t5_one_dequeue", 64'(deq_cnt - snap), 64'd1);

    // 6) reset while segment 2 is waiting, then a fresh packet
    meta_next = 32'h0000_0040;
    add_seg(10'h040, 1'b0, 10'h041, 32'h4040_4040, 1'b1, 1'b0, 2'd2);
    add_seg(10'h041, 1'b0, 10'h042, 32'h4141_4141, 1'b0, 1'b0, 2'd2);
    add_seg(10'h042, 1'b1, 10'h000, 32'h4242_4242, 1'b0, 1'b1, 2'd2);
    exp_done_q.push_back(1'b1);
    tx_ready = 1'b0;
    send_grant(2'd2);
    wait_tx_valid(50, "t6_seg1_valid");
    @(posedge clk); #1; tx_ready = 1'b1;
    @(posedge clk); #1; tx_ready = 1'b0;
    wait_tx_valid(50, "t6_seg2_valid");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_mid_reset");
    check("t6_pending_segs", 64'(exp_q.size()), 64'd2);
    check("t6_pending_frees", 64'(exp_free_q.size()), 64'd2);
    exp_q.delete();
    exp_free_q.delete();
    exp_done_q.delete();
    tx_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;

    meta_next = 32'h0000_0050;
    snap = deq_cnt;
    add_seg(10'h050, 1'b1, 10'h000, 32'h5A5A_5A5A, 1'b1, 1'b1, 2'd3);
    exp_done_q.push_back(1'b1);
    send_grant(2'd3);
    wait_done(50, "t6_fresh_done_seen");
    check("t6_fresh_latency", 64'(first_rise - g_cyc), 64'd4);
    check("t6_fresh_one_dequeue", 64'(deq_cnt - snap), 64'd1);

    repeat (5) @(negedge clk);
    check("end_tx_queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_free_queue_empty", 64'(exp_free_q.size()), 64'd0);
    check("end_done_queue_empty", 64'(exp_done_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
